// File: rtl/gyro_axil_init_seq_if.sv
// AXI-lite read/write channel bundle shared between the init sequencer and gyro_top.
// producer = AXI-lite master side, consumer = slave side.
interface axil_rw_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0]   awaddr;
    logic [2:0]      awprot;
    logic            awvalid;
    logic            awready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wvalid;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;
    logic [AW-1:0]   araddr;
    logic [2:0]      arprot;
    logic            arvalid;
    logic            arready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready;

    modport producer (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport consumer (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/gyro_axil_init_seq.sv
// Table-driven AXI-lite boot sequencer (WRITE / POLL / WAIT) that configures gyro_top after a start pulse.
// Optional per-handshake stall timeout: define GYRO_INIT_SEQ_HS_TIMEOUT_EN.
module gyro_axil_init_seq #(
    parameter int  AW         = 32,
    parameter int  DW         = 32,
    parameter int  DEPTH      = 16,
    parameter int  POLL_MAX   = 1024,
    parameter int  HS_TIMEOUT = 4096,
    localparam int IW         = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          tbl_we,
    input  logic [IW-1:0] tbl_idx,
    input  logic [1:0]    tbl_op,
    input  logic [AW-1:0] tbl_addr,
    input  logic [DW-1:0] tbl_data,
    input  logic [DW-1:0] tbl_mask,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [2:0]    err_code,
    output logic [IW-1:0] err_idx,
    axil_rw_if.producer   m_axil_if
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WR    = 3'd2;
    localparam logic [2:0] S_WR_B  = 3'd3;
    localparam logic [2:0] S_RD    = 3'd4;
    localparam logic [2:0] S_RD_R  = 3'd5;
    localparam logic [2:0] S_WAIT  = 3'd6;
    localparam logic [2:0] S_FIN   = 3'd7;

    localparam logic [1:0] OP_END   = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_POLL  = 2'd2;
    localparam logic [1:0] OP_WAIT  = 2'd3;

    localparam int RW = $clog2(POLL_MAX);

    if (DW != 32 || POLL_MAX < 2 || HS_TIMEOUT < 2) begin : g_param_check
        $error("gyro_axil_init_seq: DW must be 32, POLL_MAX and HS_TIMEOUT at least 2");
    end

    logic [1:0]    r_tbl_op   [DEPTH];
    logic [AW-1:0] r_tbl_addr [DEPTH];
    logic [DW-1:0] r_tbl_data [DEPTH];
    logic [DW-1:0] r_tbl_mask [DEPTH];

    logic [2:0]    r_state;
    logic [IW-1:0] r_idx;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;
    logic [DW-1:0] r_mask;
    logic [DW-1:0] r_wait_cnt;
    logic          r_wait_poll;
    logic [RW-1:0] r_retry;
    logic          r_err;
    logic [2:0]    r_err_code;
    logic [IW-1:0] r_err_idx;
    logic          r_awvalid;
    logic          r_wvalid;
    logic          r_bready;
    logic          r_arvalid;
    logic          r_rready;

    logic w_busy;
    logic w_last;
    logic w_match;
    logic w_aw_ok;
    logic w_w_ok;
    logic w_hs_timeout;

    assign w_busy  = (r_state != S_IDLE) && (r_state != S_FIN);
    assign w_last  = (r_idx == IW'(DEPTH - 1));
    assign w_match = ((m_axil_if.rdata & r_mask) == (r_data & r_mask));
    // A channel is finished once its valid has dropped or it is being accepted this cycle.
    assign w_aw_ok = !r_awvalid || m_axil_if.awready;
    assign w_w_ok  = !r_wvalid  || m_axil_if.wready;

`ifdef GYRO_INIT_SEQ_HS_TIMEOUT_EN
    localparam int TW = $clog2(HS_TIMEOUT + 1);

    logic [2:0]    r_state_d;
    logic [TW-1:0] r_stall;
    logic [TW-1:0] w_stall;
    logic          w_hs_state;

    // Count restarts from zero on the first cycle of every newly entered state.
    assign w_stall      = (r_state == r_state_d) ? r_stall : '0;
    assign w_hs_state   = (r_state == S_WR) || (r_state == S_WR_B) ||
                          (r_state == S_RD) || (r_state == S_RD_R);
    assign w_hs_timeout = w_hs_state && (w_stall == TW'(HS_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_d <= S_IDLE;
            r_stall   <= '0;
        end else begin
            r_state_d <= r_state;
            r_stall   <= w_hs_state ? (w_stall + 1'b1) : '0;
        end
    end
`else
    assign w_hs_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_tbl_op[i] <= OP_END;
        end else if (tbl_we && !w_busy) begin
            r_tbl_op[tbl_idx] <= tbl_op;
        end
    end

    always_ff @(posedge clk) begin
        if (tbl_we && !w_busy) begin
            r_tbl_addr[tbl_idx] <= tbl_addr;
            r_tbl_data[tbl_idx] <= tbl_data;
            r_tbl_mask[tbl_idx] <= tbl_mask;
        end
    end

    // Handshake: a valid rises only on entry to its state and falls only in the cycle its
    // valid&ready completes (or on a stall timeout); address/data registers never change while a valid is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_mask      <= '0;
            r_wait_cnt  <= '0;
            r_wait_poll <= 1'b0;
            r_retry     <= '0;
            r_err       <= 1'b0;
            r_err_code  <= 3'd0;
            r_err_idx   <= '0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_idx      <= '0;
                        r_err      <= 1'b0;
                        r_err_code <= 3'd0;
                        r_err_idx  <= '0;
                        r_state    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_addr      <= r_tbl_addr[r_idx];
                    r_data      <= r_tbl_data[r_idx];
                    r_mask      <= r_tbl_mask[r_idx];
                    r_retry     <= '0;
                    r_wait_poll <= 1'b0;
                    case (r_tbl_op[r_idx])
                        OP_WRITE: begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= S_WR;
                        end
                        OP_POLL: begin
                            r_arvalid <= 1'b1;
                            r_state   <= S_RD;
                        end
                        OP_WAIT: begin
                            r_wait_cnt <= r_tbl_data[r_idx];
                            r_state    <= S_WAIT;
                        end
                        default: r_state <= S_FIN;
                    endcase
                end
                S_WR: begin
                    if (w_hs_timeout) begin
                        r_awvalid  <= 1'b0;
                        r_wvalid   <= 1'b0;
                        r_err      <= 1'b1;
                        r_err_code <= 3'd4;
                        r_err_idx  <= r_idx;
                        r_state    <= S_FIN;
                    end else begin
                        if (r_awvalid && m_axil_if.awready) r_awvalid <= 1'b0;
                        if (r_wvalid && m_axil_if.wready) r_wvalid <= 1'b0;
                        if (w_aw_ok && w_w_ok) begin
                            r_bready <= 1'b1;
                            r_state  <= S_WR_B;
                        end
                    end
                end
                S_WR_B: begin
                    if (w_hs_timeout) begin
                        r_bready   <= 1'b0;
                        r_err      <= 1'b1;
                        r_err_code <= 3'd4;
                        r_err_idx  <= r_idx;
                        r_state    <= S_FIN;
                    end else if (m_axil_if.bvalid) begin
                        r_bready <= 1'b0;
                        if (m_axil_if.bresp != 2'b00) begin
                            r_err      <= 1'b1;
                            r_err_code <= 3'd1;
                            r_err_idx  <= r_idx;
                            r_state    <= S_FIN;
                        end else if (w_last) begin
                            r_state <= S_FIN;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_RD: begin
                    if (w_hs_timeout) begin
                        r_arvalid  <= 1'b0;
                        r_err      <= 1'b1;
                        r_err_code <= 3'd4;
                        r_err_idx  <= r_idx;
                        r_state    <= S_FIN;
                    end else if (m_axil_if.arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_RD_R;
                    end
                end
                S_RD_R: begin
                    if (w_hs_timeout) begin
                        r_rready   <= 1'b0;
                        r_err      <= 1'b1;
                        r_err_code <= 3'd4;
                        r_err_idx  <= r_idx;
                        r_state    <= S_FIN;
                    end else if (m_axil_if.rvalid) begin
                        r_rready <= 1'b0;
                        if (m_axil_if.rresp != 2'b00) begin
                            r_err      <= 1'b1;
                            r_err_code <= 3'd2;
                            r_err_idx  <= r_idx;
                            r_state    <= S_FIN;
                        end else if (w_match) begin
                            if (w_last) begin
                                r_state <= S_FIN;
                            end else begin
                                r_idx   <= r_idx + 1'b1;
                                r_state <= S_FETCH;
                            end
                        end else if (r_retry == RW'(POLL_MAX - 1)) begin
                            r_err      <= 1'b1;
                            r_err_code <= 3'd3;
                            r_err_idx  <= r_idx;
                            r_state    <= S_FIN;
                        end else begin
                            // Single idle cycle between poll attempts reuses the WAIT state.
                            r_retry     <= r_retry + 1'b1;
                            r_wait_poll <= 1'b1;
                            r_wait_cnt  <= '0;
                            r_state     <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_wait_cnt != '0) begin
                        r_wait_cnt <= r_wait_cnt - 1'b1;
                    end else if (r_wait_poll) begin
                        r_wait_poll <= 1'b0;
                        r_arvalid   <= 1'b1;
                        r_state     <= S_RD;
                    end else if (w_last) begin
                        r_state <= S_FIN;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_state <= S_FETCH;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy     = w_busy;
    assign done     = (r_state == S_FIN);
    assign err      = r_err;
    assign err_code = r_err_code;
    assign err_idx  = r_err_idx;

    assign m_axil_if.awaddr  = r_addr;
    assign m_axil_if.awprot  = 3'b000;
    assign m_axil_if.awvalid = r_awvalid;
    assign m_axil_if.wdata   = r_data;
    assign m_axil_if.wstrb   = '1;
    assign m_axil_if.wvalid  = r_wvalid;
    assign m_axil_if.bready  = r_bready;
    assign m_axil_if.araddr  = r_addr;
    assign m_axil_if.arprot  = 3'b000;
    assign m_axil_if.arvalid = r_arvalid;
    assign m_axil_if.rready  = r_rready;
endmodule

// File: tb/tb_gyro_axil_init_seq.sv
// Scoreboard bench for gyro_axil_init_seq: a small AXI-lite slave model answers the sequencer,
// directed tables push expected beats/completions, and a negedge monitor pops and compares them.
module tb_gyro_axil_init_seq;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int DEPTH = 16;
    localparam int IW = 4;

    localparam logic [1:0] OP_END   = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_POLL  = 2'd2;
    localparam logic [1:0] OP_WAIT  = 2'd3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic          start = 1'b0;
    logic          tbl_we = 1'b0;
    logic [IW-1:0] tbl_idx = '0;
    logic [1:0]    tbl_op = '0;
    logic [AW-1:0] tbl_addr = '0;
    logic [DW-1:0] tbl_data = '0;
    logic [DW-1:0] tbl_mask = '0;
    logic          busy;
    logic          done;
    logic          err;
    logic [2:0]    err_code;
    logic [IW-1:0] err_idx;

    axil_rw_if #(.AW(AW), .DW(DW)) axil ();

    gyro_axil_init_seq #(
        .AW(AW), .DW(DW), .DEPTH(DEPTH), .POLL_MAX(4), .HS_TIMEOUT(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .tbl_we(tbl_we), .tbl_idx(tbl_idx), .tbl_op(tbl_op),
        .tbl_addr(tbl_addr), .tbl_data(tbl_data), .tbl_mask(tbl_mask),
        .busy(busy), .done(done), .err(err), .err_code(err_code), .err_idx(err_idx),
        .m_axil_if(axil)
    );

    // ---------------- slave model ----------------
    logic        s_awready_en = 1'b1;
    logic        s_wready_en  = 1'b1;
    logic        s_arready_en = 1'b1;
    int          bresp_err_at = -1;
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          rd_base = 0;
    logic [31:0] poll_rdata [8];
    logic        aw_got;
    logic        w_got;

    assign axil.awready = s_awready_en;
    assign axil.wready  = s_wready_en;
    assign axil.arready = s_arready_en;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_got      <= 1'b0;
            w_got       <= 1'b0;
            axil.bvalid <= 1'b0;
            axil.bresp  <= 2'b00;
            axil.rvalid <= 1'b0;
            axil.rdata  <= '0;
            axil.rresp  <= 2'b00;
        end else begin
            if (!axil.bvalid && (aw_got || (axil.awvalid && axil.awready)) &&
                (w_got || (axil.wvalid && axil.wready))) begin
                axil.bvalid <= 1'b1;
                axil.bresp  <= (wr_cnt == bresp_err_at) ? 2'b10 : 2'b00;
                wr_cnt      <= wr_cnt + 1;
                aw_got      <= 1'b0;
                w_got       <= 1'b0;
            end else begin
                if (axil.awvalid && axil.awready) aw_got <= 1'b1;
                if (axil.wvalid && axil.wready) w_got <= 1'b1;
            end
            if (axil.bvalid && axil.bready) axil.bvalid <= 1'b0;
            if (!axil.rvalid && axil.arvalid && axil.arready) begin
                axil.rvalid <= 1'b1;
                axil.rdata  <= poll_rdata[((rd_cnt - rd_base) > 7) ? 7 : (rd_cnt - rd_base)];
                axil.rresp  <= 2'b00;
                rd_cnt      <= rd_cnt + 1;
            end
            if (axil.rvalid && axil.rready) axil.rvalid <= 1'b0;
        end
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] exp_wr_q [$];
    logic [31:0] exp_ar_q [$];
    logic [7:0]  exp_done_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic report_fail(input string name, input logic [31:0] act);
        n_checks++;
        n_errors++;
        $display("FAIL %s got=%h required=nothing (cycle %0d)", name, act, cyc);
    endtask

    logic        pend_aw = 1'b0;
    logic        pend_w = 1'b0;
    logic [31:0] pend_aw_addr = '0;
    logic [31:0] pend_w_data = '0;
    logic        prev_aw = 1'b0;
    int          last_b_cyc = 0;
    int          aw_gap = 0;
    int          aw_hi_cnt = 0;
    int          n_ar = 0;
    int          done_cnt = 0;
    logic [63:0] exp_wr;
    logic [31:0] exp_ar;
    logic [7:0]  exp_dn;

    always @(negedge clk) begin
        if (!rst_n) begin
            pend_aw = 1'b0;
            pend_w  = 1'b0;
            prev_aw = 1'b0;
        end else begin
            if (axil.awvalid && axil.awready) begin
                pend_aw = 1'b1;
                pend_aw_addr = axil.awaddr;
            end
            if (axil.wvalid && axil.wready) begin
                pend_w = 1'b1;
                pend_w_data = axil.wdata;
                check("wr_strb", 32'(axil.wstrb), 32'hF);
            end
            if (pend_aw && pend_w) begin
                if (exp_wr_q.size() == 0) begin
                    report_fail("wr_unexpected", pend_aw_addr);
                end else begin
                    exp_wr = exp_wr_q.pop_front();
                    check("wr_addr", pend_aw_addr, exp_wr[63:32]);
                    check("wr_data", pend_w_data, exp_wr[31:0]);
                end
                pend_aw = 1'b0;
                pend_w  = 1'b0;
            end
            if (axil.arvalid && axil.arready) begin
                n_ar++;
                if (exp_ar_q.size() == 0) begin
                    report_fail("ar_unexpected", axil.araddr);
                end else begin
                    exp_ar = exp_ar_q.pop_front();
                    check("ar_addr", axil.araddr, exp_ar);
                end
            end
            if (axil.bvalid && axil.bready) last_b_cyc = cyc;
            if (axil.awvalid && !prev_aw) aw_gap = cyc - last_b_cyc;
            if (axil.awvalid) aw_hi_cnt++;
            prev_aw = axil.awvalid;
            if (done) begin
                done_cnt++;
                if (exp_done_q.size() == 0) begin
                    report_fail("done_unexpected", {24'd0, err, err_code, err_idx});
                end else begin
                    exp_dn = exp_done_q.pop_front();
                    check("done_err", 32'(err), 32'(exp_dn[7]));
                    check("done_err_code", 32'(err_code), 32'(exp_dn[6:4]));
                    check("done_err_idx", 32'(err_idx), 32'(exp_dn[3:0]));
                    check("done_busy", 32'(busy), 32'd0);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input int idx, input logic [1:0] op, input logic [31:0] addr,
                        input logic [31:0] data, input logic [31:0] mask);
        step(1);
        tbl_we   = 1'b1;
        tbl_idx  = IW'(idx);
        tbl_op   = op;
        tbl_addr = addr;
        tbl_data = data;
        tbl_mask = mask;
        step(1);
        tbl_we = 1'b0;
    endtask

    task automatic pulse_start();
        step(1);
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int base;
        base = done_cnt;
        for (int i = 0; i < 400 && done_cnt == base; i++) step(1);
        if (done_cnt == base) report_fail({name, "_done_timeout"}, 32'(busy));
        step(1);
    endtask

    task automatic check_drained(input string name);
        check({name, "_wr_left"}, 32'(exp_wr_q.size()), 32'd0);
        check({name, "_ar_left"}, 32'(exp_ar_q.size()), 32'd0);
        check({name, "_done_left"}, 32'(exp_done_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_done"}, 32'(done), 32'd0);
        check({name, "_err"}, 32'(err), 32'd0);
        check({name, "_err_code"}, 32'(err_code), 32'd0);
        check({name, "_err_idx"}, 32'(err_idx), 32'd0);
        check({name, "_awvalid"}, 32'(axil.awvalid), 32'd0);
        check({name, "_wvalid"}, 32'(axil.wvalid), 32'd0);
        check({name, "_arvalid"}, 32'(axil.arvalid), 32'd0);
        check({name, "_bready"}, 32'(axil.bready), 32'd0);
        check({name, "_rready"}, 32'(axil.rready), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    int ar_base;
    int aw_base;

    initial begin
        for (int i = 0; i < 8; i++) poll_rdata[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        step(2);

        // Two back-to-back writes, all readies high.
        load(0, OP_WRITE, 32'h10, 32'hA5A5_0001, 32'h0);
        load(1, OP_WRITE, 32'h14, 32'h3, 32'h0);
        load(2, OP_END, 32'h0, 32'h0, 32'h0);
        exp_wr_q.push_back({32'h10, 32'hA5A5_0001});
        exp_wr_q.push_back({32'h14, 32'h3});
        exp_done_q.push_back({1'b0, 3'd0, 4'd0});
        pulse_start();
        wait_done("two_writes");
        check("two_writes_busy_after", 32'(busy), 32'd0);
        check_drained("two_writes");

        // POLL that matches on the fourth read.
        load(0, OP_POLL, 32'h20, 32'h1, 32'h1);
        load(1, OP_END, 32'h0, 32'h0, 32'h0);
        poll_rdata[0] = 32'h0;
        poll_rdata[1] = 32'h0;
        poll_rdata[2] = 32'h0;
        poll_rdata[3] = 32'h1;
        rd_base = rd_cnt;
        ar_base = n_ar;
        repeat (4) exp_ar_q.push_back(32'h20);
        exp_done_q.push_back({1'b0, 3'd0, 4'd0});
        pulse_start();
        wait_done("poll_ok");
        check("poll_ok_reads", 32'(n_ar - ar_base), 32'd4);
        check_drained("poll_ok");

        // POLL that never matches: POLL_MAX=4 reads then timeout code 3.
        load(0, OP_POLL, 32'h24, 32'h5A, 32'hFF);
        for (int i = 0; i < 8; i++) poll_rdata[i] = 32'h0000_0100;
        rd_base = rd_cnt;
        ar_base = n_ar;
        repeat (4) exp_ar_q.push_back(32'h24);
        exp_done_q.push_back({1'b1, 3'd3, 4'd0});
        pulse_start();
        wait_done("poll_to");
        check("poll_to_reads", 32'(n_ar - ar_base), 32'd4);
        check_drained("poll_to");

        // Entry 2 gets SLVERR; entry 3 must not be issued.
        load(0, OP_WRITE, 32'h30, 32'h0000_0030, 32'h0);
        load(1, OP_WRITE, 32'h34, 32'h0000_0034, 32'h0);
        load(2, OP_WRITE, 32'h38, 32'h0000_0038, 32'h0);
        load(3, OP_WRITE, 32'h3C, 32'h0000_003C, 32'h0);
        load(4, OP_END, 32'h0, 32'h0, 32'h0);
        bresp_err_at = wr_cnt + 2;
        exp_wr_q.push_back({32'h30, 32'h30});
        exp_wr_q.push_back({32'h34, 32'h34});
        exp_wr_q.push_back({32'h38, 32'h38});
        exp_done_q.push_back({1'b1, 3'd1, 4'd2});
        pulse_start();
        wait_done("bresp_err");
        step(3);
        check("bresp_err_sticky", 32'(err), 32'd1);
        check_drained("bresp_err");
        bresp_err_at = -1;

        // WAIT 5 between two writes: B handshake to second awvalid is 4 cycles base + 5.
        load(0, OP_WRITE, 32'h40, 32'h1, 32'h0);
        load(1, OP_WAIT, 32'h0, 32'd5, 32'h0);
        load(2, OP_WRITE, 32'h44, 32'h2, 32'h0);
        load(3, OP_END, 32'h0, 32'h0, 32'h0);
        exp_wr_q.push_back({32'h40, 32'h1});
        exp_wr_q.push_back({32'h44, 32'h2});
        exp_done_q.push_back({1'b0, 3'd0, 4'd0});
        pulse_start();
        step(1);
        check("start_clears_err", 32'(err), 32'd0);
        wait_done("wait5");
        check("wait5_gap", 32'(aw_gap), 32'd9);
        check_drained("wait5");

        // Asynchronous reset while awvalid is held by a stalled slave.
        load(0, OP_WRITE, 32'h50, 32'h55, 32'h0);
        load(1, OP_END, 32'h0, 32'h0, 32'h0);
        s_awready_en = 1'b0;
        pulse_start();
        for (int i = 0; i < 20 && !axil.awvalid; i++) step(1);
        check("mid_rst_awvalid_before", 32'(axil.awvalid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        step(2);
        rst_n = 1'b1;
        s_awready_en = 1'b1;
        step(1);
        // Table ops were cleared by reset, so entry 0 is END and no AXI traffic may appear.
        exp_done_q.push_back({1'b0, 3'd0, 4'd0});
        pulse_start();
        wait_done("after_rst");
        check_drained("after_rst");

`ifdef GYRO_INIT_SEQ_HS_TIMEOUT_EN
        // awready stuck low: 16 cycles of awvalid in WR, then code 4 with valids dropped.
        load(0, OP_WRITE, 32'h60, 32'h7, 32'h0);
        load(1, OP_END, 32'h0, 32'h0, 32'h0);
        s_awready_en = 1'b0;
        aw_base = aw_hi_cnt;
        exp_done_q.push_back({1'b1, 3'd4, 4'd0});
        pulse_start();
        wait_done("hs_to");
        check("hs_to_aw_cycles", 32'(aw_hi_cnt - aw_base), 32'd16);
        check("hs_to_awvalid_low", 32'(axil.awvalid), 32'd0);
        check_drained("hs_to");
        s_awready_en = 1'b1;
`else
        aw_base = aw_hi_cnt;
        step(4);
        check("idle_no_awvalid", 32'(aw_hi_cnt - aw_base), 32'd0);
`endif

        step(2);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
